// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : RV32M iterative multiply (shift-add) / divide (restoring) unit
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int              c_CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_valid;
  logic                r_busy;
  logic [XLEN-1:0]     r_result;
  logic [c_CNT_W-1:0]  r_count;
  logic [2:0]          r_funct3;
  logic                r_negQ;
  logic                r_negR;
  logic [XLEN-1:0]     r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;

  // Operand decode at accept time
  logic                w_signedA;
  logic                w_signedB;
  logic                w_signA;
  logic                w_signB;
  logic [XLEN-1:0]     w_magA;
  logic [XLEN-1:0]     w_magB;
  logic                w_divZero;
  logic                w_overflow;
  logic                w_fast;
  logic [XLEN-1:0]     w_fastResult;
  logic                w_accept;

  assign w_signedA    = (i_funct3 == 3'd1) | (i_funct3 == 3'd2) |
                        (i_funct3 == 3'd4) | (i_funct3 == 3'd6);
  assign w_signedB    = (i_funct3 == 3'd1) | (i_funct3 == 3'd4) | (i_funct3 == 3'd6);
  assign w_signA      = w_signedA & i_rs1[XLEN-1];
  assign w_signB      = w_signedB & i_rs2[XLEN-1];
  assign w_magA       = w_signA ? (~i_rs1 + 1'b1) : i_rs1;
  assign w_magB       = w_signB ? (~i_rs2 + 1'b1) : i_rs2;
  assign w_divZero    = i_funct3[2] & (i_rs2 == '0);
  assign w_overflow   = ((i_funct3 == 3'd4) | (i_funct3 == 3'd6)) &
                        (i_rs1 == c_MIN_INT) & (i_rs2 == '1);
  assign w_fast       = w_divZero | w_overflow;
  assign w_fastResult = w_divZero ? (i_funct3[1] ? i_rs1 : '1)
                                  : (i_funct3[1] ? '0 : c_MIN_INT);
  assign w_accept     = (r_state == S_IDLE) & i_start & ~i_flush;

  // Multiply step: acc = {hi, multiplier}; add multiplicand to hi on lsb, shift right
  logic [XLEN:0]       w_mulSum;
  logic [2*XLEN-1:0]   w_accNext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_mulRes;

  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
  assign w_accNext = {w_mulSum, r_acc[XLEN-1:1]};
  assign w_prod    = r_negQ ? (~w_accNext + 1'b1) : w_accNext;
  assign w_mulRes  = (r_funct3[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Restoring divide step on the (XLEN+1)-bit shifted partial remainder
  logic [XLEN:0]       w_shifted;
  logic                w_ge;
  logic [XLEN-1:0]     w_sub;
  logic [XLEN-1:0]     w_remNext;
  logic [XLEN-1:0]     w_quoNext;
  logic [XLEN-1:0]     w_divRes;

  assign w_shifted = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = w_shifted >= {1'b0, r_op};
  assign w_sub     = w_shifted[XLEN-1:0] - r_op;
  assign w_remNext = w_ge ? w_sub : w_shifted[XLEN-1:0];
  assign w_quoNext = {r_quo[XLEN-2:0], w_ge};
  assign w_divRes  = r_funct3[1] ? (r_negR ? (~w_remNext + 1'b1) : w_remNext)
                                 : (r_negQ ? (~w_quoNext + 1'b1) : w_quoNext);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
      r_funct3 <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_op     <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_funct3 <= i_funct3;
            r_negQ   <= w_signA ^ w_signB;
            r_negR   <= w_signA;
            r_count  <= c_CNT_W'(XLEN - 1);
            r_op     <= i_funct3[2] ? w_magB : w_magA;
            r_acc    <= {{XLEN{1'b0}}, w_magB};
            r_rem    <= '0;
            r_quo    <= w_magA;
            if (w_fast) begin
              r_result <= w_fastResult;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_funct3[2]) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
          end else begin
            r_acc <= w_accNext;
          end
          if (r_count == '0) begin
            r_result <= r_funct3[2] ? w_divRes : w_mulRes;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall  = w_accept | (r_state == S_BUSY);
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : randomized self-checking bench for muldiv_sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            i_clk;
  logic            i_rstn;
  logic            i_start;
  logic            i_flush;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            o_stall;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_start  (i_start),
    .i_flush  (i_flush),
    .i_funct3 (i_funct3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_stall  (o_stall),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / 32-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa;
    int                 sb;
    sa = a;
    sb = b;
    up = {32'd0, a} * {32'd0, b};
    case (f)
      3'd0: return up[31:0];
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});       return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op, then check result, latency, stall length and single-cycle valid
  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          expLat;
    int          lat;
    int          stalls;
    bit          seen;
    exp    = refModel(f, a, b);
    expLat = isFast(f, a, b) ? 1 : XLEN + 1;
    @(negedge i_clk);
    i_funct3 = f;
    i_rs1    = a;
    i_rs2    = b;
    i_start  = 1'b1;
    #1;
    stalls = o_stall ? 1 : 0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    seen    = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      if (o_stall) stalls++;
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    if (!seen) begin
      checkVal({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkVal({tag, " result"}, o_result, exp);
      checkVal({tag, " latency"}, lat, expLat);
      checkVal({tag, " stalls"}, stalls, expLat);
      @(posedge i_clk);
      #1;
      checkVal({tag, " valid pulse"}, {31'd0, o_valid}, 32'd0);
      checkVal({tag, " result hold"}, o_result, exp);
    end
  endtask

  initial begin
    logic [31:0] pool [6];
    i_rstn   = 1'b0;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_funct3 = 3'd0;
    i_rs1    = '0;
    i_rs2    = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkVal("reset busy", {31'd0, o_busy}, 32'd0);
    checkVal("reset valid", {31'd0, o_valid}, 32'd0);
    checkVal("reset result", o_result, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    runOp("MUL 7x-3", 3'd0, 32'h7, 32'hFFFF_FFFD);
    runOp("MULH min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    runOp("MULHSU min", 3'd2, 32'h8000_0000, 32'h8000_0000);
    runOp("MULHU min", 3'd3, 32'h8000_0000, 32'h8000_0000);
    runOp("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    runOp("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    runOp("DIVU 100/7", 3'd5, 32'd100, 32'd7);
    runOp("REMU 100/7", 3'd7, 32'd100, 32'd7);
    runOp("DIV x/0", 3'd4, 32'h1234, 32'd0);
    runOp("REMU x/0", 3'd7, 32'h1234, 32'd0);
    runOp("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // start together with flush in IDLE is not accepted
    @(negedge i_clk);
    i_funct3 = 3'd5; i_rs1 = 32'd50; i_rs2 = 32'd3; i_start = 1'b1; i_flush = 1'b1;
    #1;
    checkVal("flush+start stall", {31'd0, o_stall}, 32'd0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_flush = 1'b0;
    checkVal("flush+start busy", {31'd0, o_busy}, 32'd0);

    // flush at BUSY cycle 10
    @(negedge i_clk);
    i_funct3 = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd9; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    checkVal("pre-flush busy", {31'd0, o_busy}, 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    checkVal("flush busy", {31'd0, o_busy}, 32'd0);
    checkVal("flush stall", {31'd0, o_stall}, 32'd0);
    begin
      int vcount = 0;
      repeat (40) begin
        @(posedge i_clk);
        #1;
        if (o_valid) vcount++;
      end
      checkVal("flush no valid", vcount, 32'd0);
    end
    runOp("MUL 3x5", 3'd0, 32'd3, 32'd5);

    // asynchronous reset mid-BUSY
    @(negedge i_clk);
    i_funct3 = 3'd0; i_rs1 = 32'd11; i_rs2 = 32'd13; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    checkVal("async rst busy", {31'd0, o_busy}, 32'd0);
    checkVal("async rst valid", {31'd0, o_valid}, 32'd0);
    checkVal("async rst result", o_result, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    runOp("MULHU -1x-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // randomized ops biased toward corner operands
    pool[0] = 32'd0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'd1; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'd2;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      runOp($sformatf("rand%0d f%0d", n, f), f, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the execute stage.
- Accepts already-forwarded operands and funct3 from execute and runs an iterative shift-add multiplier or restoring divider, one bit per cycle.
- Holds the pipeline via o_stall until the result is ready.
- Short-circuits the architecturally defined divide corner cases in one cycle.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  asynchronous active-low reset.
i_start  input  1  execute stage holds an M-extension op (opcode OP, funct7=0000001).
i_flush  input  1  pipeline flush; aborts any in-flight operation.
i_funct3  input  3  M op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
i_rs1  input  XLEN  forwarded operand A (dividend / multiplicand).
i_rs2  input  XLEN  forwarded operand B (divisor / multiplier).
o_stall  output  1  freeze IF/ID/EX; combinational.
o_valid  output  1  o_result valid this cycle; registered.
o_result  output  XLEN  result; registered.
o_busy  output  1  state is BUSY; registered.

Behaviour:
- Reset: async assert sets state IDLE and clears o_valid, o_result, o_busy, iteration counter, all datapath regs. Reset mid-operation discards the operation with no o_valid. The first accept is possible on the first rising edge after deassert.
- States and transitions:
  - IDLE, no start: stays IDLE.
  - IDLE, start (i_start & !i_flush): accept. Latch funct3 and operand signs, and load operand magnitudes. Signed handling: MULH/DIV/REM treat both operands as signed; MULHSU treats only rs1 as signed; U ops and MUL use raw values. Counter = XLEN-1.
    - Divide op with rs2==0 → DONE (fast path).
    - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF → DONE (fast path).
    - Otherwise → BUSY.
  - BUSY: one iteration per cycle.
    - Multiply: 2*XLEN accumulator, conditional add of multiplicand, then shift.
    - Divide: restoring step on a (XLEN+1)-bit partial remainder, shifting in one quotient bit.
    - When counter==0, apply sign fixup and go to DONE. Otherwise decrement the counter.
  - DONE: o_valid=1 for exactly one cycle with o_result stable, then → IDLE. i_start is ignored in DONE; back-to-back ops re-accept from IDLE, so a new op starts no earlier than the cycle after DONE.
- i_flush in any state: next state IDLE, o_valid=0 next cycle, result discarded. i_flush together with i_start in IDLE means not accepted.
- o_stall = (state==IDLE & i_start & !i_flush) | state==BUSY. It is low in DONE so the pipeline advances and captures o_result in that same cycle.
- Latency:
  - Normal: start accepted at edge T, BUSY for XLEN cycles, o_valid in cycle T+XLEN+1. o_stall is high for XLEN+1 cycles.
  - Fast path: o_valid in cycle T+1, o_stall high for 1 cycle.
- Results:
  - MUL = product[XLEN-1:0]. MULH/MULHSU/MULHU = product[2XLEN-1:XLEN], with the full 2XLEN product negated when the operand signs differ (signed cases).
  - DIV quotient is negated if the signs differ. REM remainder takes the dividend's sign. DIVU/REMU have no fixup.
- Corner cases:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = rs1.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- o_result holds its last value outside DONE. o_busy = (state==BUSY).
- All arithmetic is modulo 2^XLEN. There are no X-propagating paths and no latches.

Test Plan:
- MUL 7×(−3), i.e. rs1=0x7, rs2=0xFFFFFFFD, funct3=0 → o_stall high 33 cycles; o_valid at T+33 with 0xFFFFFFEB; o_valid high exactly 1 cycle.
- MULH/MULHSU/MULHU with rs1=rs2=0x80000000 → 0x40000000, 0xC0000000 and 0x40000000 respectively.
- DIV −7/2 and REM −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV x/0 with rs1=0x1234 → 0xFFFFFFFF at T+1, o_stall high 1 cycle. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Start a DIVU, assert i_flush at BUSY cycle 10 → state returns to IDLE next cycle with no o_valid. A following MUL 3×5 completes normally to 15.
- Pull i_rstn low asynchronously mid-BUSY (between clock edges) → o_busy/o_valid/o_result go to 0 immediately. After release, a MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
